// File: rtl/vga_timing_pkg.sv
// Mode tables and helpers shared by the VGA timing generator and its axis counters.
package vga_timing_pkg;

    localparam int DEFAULT_CNT_W = 10;

    typedef struct packed {
        int   disp;
        int   fp;
        int   sync;
        int   bp;
        logic pol;
    } axis_mode_t;

    // Standard VESA modes; pol is the asserted sync level (0 = active-low).
    localparam axis_mode_t MODE_640X480_H  = '{disp: 640,  fp: 16, sync: 96,  bp: 48,  pol: 1'b0};
    localparam axis_mode_t MODE_640X480_V  = '{disp: 480,  fp: 10, sync: 2,   bp: 33,  pol: 1'b0};
    localparam axis_mode_t MODE_800X600_H  = '{disp: 800,  fp: 40, sync: 128, bp: 88,  pol: 1'b1};
    localparam axis_mode_t MODE_800X600_V  = '{disp: 600,  fp: 1,  sync: 4,   bp: 23,  pol: 1'b1};
    localparam axis_mode_t MODE_1024X768_H = '{disp: 1024, fp: 24, sync: 136, bp: 160, pol: 1'b0};
    localparam axis_mode_t MODE_1024X768_V = '{disp: 768,  fp: 3,  sync: 6,   bp: 29,  pol: 1'b0};

    function automatic int axis_total(input int disp, input int fp, input int sync, input int bp);
        return disp + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter plus registered active/sync/coordinate decode.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   CNT_W = DEFAULT_CNT_W,
    parameter int   DISP  = 640,
    parameter int   FP    = 16,
    parameter int   SYNC  = 96,
    parameter int   BP    = 48,
    parameter logic POL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    output logic             wrap,
    output logic             active,
    output logic             sync,
    output logic [CNT_W-1:0] coord
);

    localparam int               TOTAL   = axis_total(DISP, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] DISP_C  = CNT_W'(DISP);
    localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(DISP + FP);
    localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(DISP + FP + SYNC);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             at_last;

    always_comb begin
        at_last = (cnt == LAST);
        wrap    = adv & at_last;
        cnt_nxt = cnt;
        if (adv) begin
            cnt_nxt = at_last ? '0 : cnt + CNT_W'(1);
        end
    end

    // Decoding the next count keeps every output aligned with the counter it describes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            active <= 1'b1;
            sync   <= ~POL;
            coord  <= '0;
        end else begin
            cnt    <= cnt_nxt;
            active <= (cnt_nxt < DISP_C);
            sync   <= ((cnt_nxt >= SYNC_LO) && (cnt_nxt < SYNC_HI)) ? POL : ~POL;
            coord  <= (cnt_nxt < DISP_C) ? cnt_nxt : '0;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/timing generator advancing on pix_en.
// Optional frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CNT_W  = DEFAULT_CNT_W,
    parameter int   H_DISP = MODE_640X480_H.disp,
    parameter int   H_FP   = MODE_640X480_H.fp,
    parameter int   H_SYNC = MODE_640X480_H.sync,
    parameter int   H_BP   = MODE_640X480_H.bp,
    parameter int   V_DISP = MODE_640X480_V.disp,
    parameter int   V_FP   = MODE_640X480_V.fp,
    parameter int   V_SYNC = MODE_640X480_V.sync,
    parameter int   V_BP   = MODE_640X480_V.bp,
    parameter logic H_POL  = MODE_640X480_H.pol,
    parameter logic V_POL  = MODE_640X480_V.pol
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    output logic             h_sync,
    output logic             v_sync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int     H_TOTAL   = axis_total(H_DISP, H_FP, H_SYNC, H_BP);
    localparam int     V_TOTAL   = axis_total(V_DISP, V_FP, V_SYNC, V_BP);
    localparam longint MAX_TOTAL = longint'(1) << CNT_W;

    generate
        if (H_DISP == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
            V_DISP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_segment
            $error("vga_timing_gen: every display, porch and sync width must be non-zero");
        end
        if (longint'(H_TOTAL) > MAX_TOTAL || longint'(V_TOTAL) > MAX_TOTAL) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the range of CNT_W");
        end
    endgenerate

    logic h_wrap;
    logic v_wrap;
    logic h_active;
    logic v_active;

    vga_axis_counter #(
        .CNT_W (CNT_W),
        .DISP  (H_DISP),
        .FP    (H_FP),
        .SYNC  (H_SYNC),
        .BP    (H_BP),
        .POL   (H_POL)
    ) u_h_axis (
        .clk    (clk),
        .rst    (rst),
        .adv    (pix_en),
        .wrap   (h_wrap),
        .active (h_active),
        .sync   (h_sync),
        .coord  (pixel_x)
    );

    // The vertical axis steps once per horizontal wrap, so v_sync changes on line boundaries.
    vga_axis_counter #(
        .CNT_W (CNT_W),
        .DISP  (V_DISP),
        .FP    (V_FP),
        .SYNC  (V_SYNC),
        .BP    (V_BP),
        .POL   (V_POL)
    ) u_v_axis (
        .clk    (clk),
        .rst    (rst),
        .adv    (h_wrap),
        .wrap   (v_wrap),
        .active (v_active),
        .sync   (v_sync),
        .coord  (pixel_y)
    );

    assign video_on = h_active & v_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= h_wrap;
            frame_start <= h_wrap & v_wrap;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (h_wrap && v_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a small mode so several frames fit in a short run.
module tb_vga_timing_gen;

    localparam int   CNT_W  = 5;
    localparam int   HD     = 8;
    localparam int   HF     = 2;
    localparam int   HS     = 3;
    localparam int   HB     = 2;
    localparam int   VD     = 6;
    localparam int   VF     = 1;
    localparam int   VS     = 2;
    localparam int   VB     = 2;
    localparam logic H_POL  = 1'b1;
    localparam logic V_POL  = 1'b0;
    localparam int   HT     = HD + HF + HS + HB;
    localparam int   VT     = VD + VF + VS + VB;
    localparam int   FRAME  = HT * VT;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pix_en = 1'b0;
    logic             h_sync;
    logic             v_sync;
    logic             video_on;
    logic [CNT_W-1:0] pixel_x;
    logic [CNT_W-1:0] pixel_y;
    logic             line_start;
    logic             frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0]      frame_cnt;
`endif

    vga_timing_gen #(
        .CNT_W  (CNT_W),
        .H_DISP (HD),
        .H_FP   (HF),
        .H_SYNC (HS),
        .H_BP   (HB),
        .V_DISP (VD),
        .V_FP   (VF),
        .V_SYNC (VS),
        .V_BP   (VB),
        .H_POL  (H_POL),
        .V_POL  (V_POL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .line_start  (line_start),
        .frame_start (frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             video_on;
        logic             h_sync;
        logic             v_sync;
        logic [CNT_W-1:0] pixel_x;
        logic [CNT_W-1:0] pixel_y;
        logic             line_start;
        logic             frame_start;
        logic [15:0]      frame_cnt;
    } exp_t;

    exp_t   exp_q[$];
    int     compared = 0;
    int     mismatched = 0;
    longint pix_count = 0;

    // Reference: position is simply the number of pixel advances since reset, taken modulo the mode.
    function automatic exp_t model(input longint n, input bit advanced);
        exp_t e;
        int   h;
        int   v;
        h = int'(n % HT);
        v = int'((n / HT) % VT);
        e.video_on    = (h < HD) && (v < VD);
        e.h_sync      = (h >= HD + HF && h < HD + HF + HS) ? H_POL : ~H_POL;
        e.v_sync      = (v >= VD + VF && v < VD + VF + VS) ? V_POL : ~V_POL;
        e.pixel_x     = (h < HD) ? CNT_W'(h) : '0;
        e.pixel_y     = (v < VD) ? CNT_W'(v) : '0;
        e.line_start  = advanced && (h == 0);
        e.frame_start = advanced && (n % FRAME == 0);
        e.frame_cnt   = 16'(n / FRAME);
        return e;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d (pixel %0d)", name, $time, actual, expected, pix_count);
        end
    endtask

    task automatic check_all(input exp_t e);
        check_output("video_on",    32'(video_on),    32'(e.video_on));
        check_output("h_sync",      32'(h_sync),      32'(e.h_sync));
        check_output("v_sync",      32'(v_sync),      32'(e.v_sync));
        check_output("pixel_x",     32'(pixel_x),     32'(e.pixel_x));
        check_output("pixel_y",     32'(pixel_y),     32'(e.pixel_y));
        check_output("line_start",  32'(line_start),  32'(e.line_start));
        check_output("frame_start", 32'(frame_start), 32'(e.frame_start));
`ifdef VGA_TIMING_FRAME_CNT_EN
        check_output("frame_cnt",   32'(frame_cnt),   32'(e.frame_cnt));
`endif
    endtask

    // mode 0: pix_en held high; 1: random; 2: alternating 1,0
    task automatic apply_stimulus(input int cycles, input int mode);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            case (mode)
                0:       pix_en = 1'b1;
                1:       pix_en = 1'($urandom_range(0, 1));
                default: pix_en = (i % 2 == 0);
            endcase
            if (pix_en) pix_count++;
            exp_q.push_back(model(pix_count, pix_en));
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_all(e);
            end
        end
    end

    initial begin : stimulus
        rst    = 1'b1;
        pix_en = 1'b0;
        #12;
        check_all(model(0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        pix_count = 0;

        apply_stimulus(2 * FRAME + 20, 0);
        apply_stimulus(2 * FRAME, 1);
        apply_stimulus(2 * FRAME, 2);
        apply_stimulus(FRAME / 2 + 7, 1);

        // Asynchronous reset between edges, mid-frame
        @(posedge clk);
        #3;
        pix_en = 1'b0;
        rst    = 1'b1;
        #1;
        check_all(model(0, 1'b0));
        pix_count = 0;
        @(negedge clk);
        rst = 1'b0;

        apply_stimulus(FRAME + HT + 3, 0);
        apply_stimulus(FRAME, 1);

        @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
